// File: rtl/score_display_pkg.sv
// Shared types, segment patterns and sizing helpers for the score display.
// Sizing functions are constant-evaluable so they can set parameters.
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int pow10(input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic int shift_w(input int d);
        return $clog2(pow10(d));
    endfunction

    function automatic int clamp_max(input int d);
        return pow10(d) - 1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/score_display_bcd_converter.sv
// Sequential double-dabble binary to BCD converter.
// Only a finished conversion is committed to the bcd output.
module bcd_converter
    import score_display_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int SHIFT_W = 14
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic [31:0]           raw,
    input  logic [SHIFT_W-1:0]    value,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(SHIFT_W + 1);

    conv_state_t          state;
    logic [SHIFT_W-1:0]   sr;
    logic [4*DIGITS-1:0]  acc;
    logic [4*DIGITS-1:0]  adj;
    logic [31:0]          cap;
    logic [31:0]          last_score;
    logic [CNT_W-1:0]     cnt;

    assign busy = (state != IDLE);

    // Add-3 correction on every BCD nibble that would overflow on shift
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Conversion FSM and shift datapath
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state      <= IDLE;
            sr         <= '0;
            acc        <= '0;
            cap        <= '0;
            last_score <= '0;
            cnt        <= '0;
            bcd        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (raw != last_score)
                        state <= LOAD;
                end
                LOAD: begin
                    sr    <= value;
                    acc   <= '0;
                    cap   <= raw;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {acc, sr} <= {adj, sr} << 1;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CNT_W'(SHIFT_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd        <= acc;
                    last_score <= cap;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// Score display: clamps the score, converts to BCD and scans the
// digits onto an active-low multiplexed 7-segment display.
module score_display
    import score_display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic [31:0]           data_score,
    input  logic [31:0]           data_rstatus,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  dp_n,
    output logic                  conv_busy,
    output logic [4*DIGITS-1:0]   score_bcd
);

    localparam int SHIFT_W = shift_w(DIGITS);
    localparam int MAX_VAL = clamp_max(DIGITS);
    localparam int CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SHIFT_W-1:0] clamped;
    logic [CW-1:0]      refresh_cnt;
    logic [IW-1:0]      idx;
    logic [3:0]         nib;
    logic               blank;
    logic [DIGITS-1:0]  an_cur;
    logic               unused_rstatus;

    assign unused_rstatus = ^data_rstatus[31:1];

    // Negative scores show as zero, oversize scores saturate
    always_comb begin
        if (data_score[31])
            clamped = '0;
        else if (data_score > 32'(MAX_VAL))
            clamped = SHIFT_W'(MAX_VAL);
        else
            clamped = data_score[SHIFT_W-1:0];
    end

    bcd_converter #(
        .DIGITS  (DIGITS),
        .SHIFT_W (SHIFT_W)
    ) u_conv (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .raw          (data_score),
        .value        (clamped),
        .busy         (conv_busy),
        .bcd          (score_bcd)
    );

    // Select the current digit, its anode and its leading-zero blanking
    always_comb begin
        nib    = 4'd0;
        blank  = 1'b0;
        an_cur = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = score_bcd[4*i +: 4];
                blank     = (i != 0) && ((score_bcd >> (4*i)) == '0);
                an_cur[i] = 1'b0;
            end
        end
    end

    // Refresh timer, digit scan and registered display drive
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            refresh_cnt <= '0;
            idx         <= '0;
            seg_n       <= SEG_BLANK;
            an_n        <= '1;
            dp_n        <= 1'b1;
        end else begin
            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                if (idx == IW'(DIGITS - 1))
                    idx <= '0;
                else
                    idx <= idx + 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            seg_n <= blank ? SEG_BLANK : seg_decode(nib);
            an_n  <= an_cur;
            dp_n  <= ~(data_rstatus[0] && (idx == '0));
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: reset, conversions, clamping,
// mid-conversion changes, async reset and the digit scan.
module tb_score_display;

    localparam int R = 4;

    logic        clock;
    logic        ctrl_reset_n;
    logic [31:0] data_score;
    logic [31:0] data_rstatus;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        conv_busy;
    logic [15:0] score_bcd;

    int total = 0;
    int bad   = 0;
    logic [15:0] cur_bcd = 16'h0;

    typedef struct {
        logic [31:0] score;
        logic [15:0] bcd;
    } vec_t;

    vec_t vecs[9];

    score_display #(
        .DIGITS      (4),
        .REFRESH_DIV (R)
    ) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .data_score   (data_score),
        .data_rstatus (data_rstatus),
        .seg_n        (seg_n),
        .an_n         (an_n),
        .dp_n         (dp_n),
        .conv_busy    (conv_busy),
        .score_bcd    (score_bcd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [15:0] b, input int d);
        logic [15:0] s;
        logic [6:0]  r;
        s = b >> (4*d);
        if (d != 0 && s == 16'h0) return 7'h7F;
        case (s[3:0])
            4'd0: r = 7'h40;  4'd1: r = 7'h79;
            4'd2: r = 7'h24;  4'd3: r = 7'h30;
            4'd4: r = 7'h19;  4'd5: r = 7'h12;
            4'd6: r = 7'h02;  4'd7: r = 7'h78;
            4'd8: r = 7'h00;  4'd9: r = 7'h10;
            default: r = 7'h7F;
        endcase
        return r;
    endfunction

    // Caller is at a negedge with the converter idle
    task automatic do_conv(input logic [31:0] v, input logic [15:0] exp,
                           input string name);
        int busy_n;
        logic [15:0] old;
        old = cur_bcd;
        busy_n = 0;
        data_score = v;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (conv_busy) busy_n++;
            if (k == 16) chk({name, " early"}, 32'(score_bcd), 32'(old));
            if (k == 17) begin
                chk({name, " bcd"}, 32'(score_bcd), 32'(exp));
                chk({name, " idle"}, 32'(conv_busy), 32'd0);
            end
        end
        chk({name, " busy_len"}, busy_n, 16);
        cur_bcd = exp;
    endtask

    task automatic scan_check(input logic [15:0] b, input logic rs,
                              input string name);
        int prev, run, d, seen;
        bit full;
        prev = -1; run = 0; seen = 0; full = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            case (an_n)
                4'hE: d = 0;
                4'hD: d = 1;
                4'hB: d = 2;
                4'h7: d = 3;
                default: d = -1;
            endcase
            chk({name, " an_onehot"}, 32'(d >= 0), 32'd1);
            if (d >= 0) begin
                chk($sformatf("%s seg d%0d", name, d), 32'(seg_n),
                    32'(ref_seg(b, d)));
                chk($sformatf("%s dp d%0d", name, d), 32'(dp_n),
                    32'(!(rs && d == 0)));
                seen = seen | (1 << d);
                if (d != prev) begin
                    if (prev >= 0) begin
                        chk({name, " order"}, d, (prev + 1) % 4);
                        if (full) chk({name, " dwell"}, run, R);
                        full = 1;
                    end
                    prev = d;
                    run = 1;
                end else begin
                    run++;
                end
            end
        end
        chk({name, " all_digits"}, seen, 15);
    endtask

    initial begin
        vecs[0] = '{32'd1234,       16'h1234};
        vecs[1] = '{32'd123456,     16'h9999};
        vecs[2] = '{32'hFFFF_FFFF,  16'h0000};
        vecs[3] = '{32'd10000,      16'h9999};
        vecs[4] = '{32'd9999,       16'h9999};
        vecs[5] = '{32'd7,          16'h0007};
        vecs[6] = '{32'h8000_0000,  16'h0000};
        vecs[7] = '{32'd1000,       16'h1000};
        vecs[8] = '{32'd305,        16'h0305};

        ctrl_reset_n = 1'b0;
        data_score   = 32'd0;
        data_rstatus = 32'd0;

        repeat (2) @(negedge clock);
        chk("rst seg", 32'(seg_n), 32'h7F);
        chk("rst an", 32'(an_n), 32'hF);
        chk("rst dp", 32'(dp_n), 32'd1);
        chk("rst busy", 32'(conv_busy), 32'd0);
        chk("rst bcd", 32'(score_bcd), 32'h0);

        ctrl_reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst an", 32'(an_n), 32'hE);
        chk("post_rst seg", 32'(seg_n), 32'h40);
        chk("post_rst busy", 32'(conv_busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_conv(vecs[i].score, vecs[i].bcd, $sformatf("vec%0d", i));
            scan_check(vecs[i].bcd, 1'b0, $sformatf("scan%0d", i));
        end

        // Score changes while a conversion is running
        data_score = 32'd1234;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            chk($sformatf("midchg k%0d", k), 32'(score_bcd),
                32'(k < 17 ? cur_bcd : (k < 34 ? 16'h1234 : 16'h0042)));
            if (k == 5) data_score = 32'd42;
        end
        cur_bcd = 16'h0042;

        data_rstatus = 32'd1;
        scan_check(16'h0042, 1'b1, "gameover");
        data_rstatus = 32'd0;
        scan_check(16'h0042, 1'b0, "gameover_off");

        // Asynchronous reset in the middle of SHIFT
        data_score = 32'd55;
        repeat (6) @(negedge clock);
        chk("pre_rst busy", 32'(conv_busy), 32'd1);
        #2 ctrl_reset_n = 1'b0;
        #1;
        chk("arst seg", 32'(seg_n), 32'h7F);
        chk("arst an", 32'(an_n), 32'hF);
        chk("arst dp", 32'(dp_n), 32'd1);
        chk("arst busy", 32'(conv_busy), 32'd0);
        chk("arst bcd", 32'(score_bcd), 32'h0);
        cur_bcd = 16'h0;
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        do_conv(32'd55, 16'h0055, "rearm");
        scan_check(16'h0055, 1'b0, "scan55");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
